// File: rtl/load_extend_unit_if.sv
// Load request, data-memory read and result channels of the load extend unit.
// The unit is the slave; the requester/memory/consumer side is the master.
interface load_extend_unit_if;
    logic        ld_valid;
    logic        ld_ready;
    logic [5:0]  opcode;
    logic [1:0]  xo;
    logic [63:0] address;
    logic        mem_req;
    logic [60:0] mem_addr;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic [1:0]  res_err_code;

    modport master (
        output ld_valid, opcode, xo, address, mem_ack, mem_rdata, res_ready,
        input  ld_ready, mem_req, mem_addr, res_valid, res_data, res_err_code
    );

    modport slave (
        input  ld_valid, opcode, xo, address, mem_ack, mem_rdata, res_ready,
        output ld_ready, mem_req, mem_addr, res_valid, res_data, res_err_code
    );
endinterface

// File: rtl/load_extend_unit.sv
// Single-outstanding uPower load unit: decodes the load, fetches the doubleword,
// extracts the little-endian lane and zero/sign-extends it, with an ack timeout.
module load_extend_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic               clk,
    input logic               rst_n,
    load_extend_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;

    typedef struct packed {
        logic  legal;
        size_t size;
        logic  sgn;
    } dec_t;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;
    localparam logic [7:0] CNT_LAST     = 8'(TIMEOUT - 1);

    function automatic dec_t decode(input logic [5:0] op, input logic [1:0] x);
        dec_t d;
        d.legal = 1'b1;
        d.size  = SZ_B;
        d.sgn   = 1'b0;
        case (op)
            6'd34: d.size = SZ_B;
            6'd40: d.size = SZ_H;
            6'd42: begin d.size = SZ_H; d.sgn = 1'b1; end
            6'd32: d.size = SZ_W;
            6'd58: begin
                if (x == 2'd0) begin
                    d.size = SZ_D;
                end else if (x == 2'd2) begin
                    d.size = SZ_W;
                    d.sgn  = 1'b1;
                end else begin
                    d.legal = 1'b0;
                end
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic is_aligned(input size_t sz, input logic [2:0] off);
        logic ok;
        case (sz)
            SZ_H:    ok = (off[0] == 1'b0);
            SZ_W:    ok = (off[1:0] == 2'b00);
            SZ_D:    ok = (off == 3'b000);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Shift the addressed lane down to bit 0, then extend above the field width.
    function automatic logic [63:0] extract(input logic [63:0] rdata, input logic [2:0] off,
                                            input size_t sz, input logic sgn);
        logic [63:0] sh;
        logic [63:0] r;
        sh = rdata >> {off, 3'b000};
        case (sz)
            SZ_B:    r = {{56{sgn & sh[7]}},  sh[7:0]};
            SZ_H:    r = {{48{sgn & sh[15]}}, sh[15:0]};
            SZ_W:    r = {{32{sgn & sh[31]}}, sh[31:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    size_t       size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [2:0]  off_q, off_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ld_ready_q, ld_ready_d;
    logic        mem_req_q, mem_req_d;
    logic [60:0] mem_addr_q, mem_addr_d;
    logic        res_valid_q, res_valid_d;
    logic [63:0] res_data_q, res_data_d;
    logic [1:0]  res_err_q, res_err_d;
    dec_t        dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            size_q      <= SZ_B;
            sgn_q       <= 1'b0;
            off_q       <= 3'd0;
            cnt_q       <= 8'd0;
            ld_ready_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 61'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= 64'd0;
            res_err_q   <= ERR_OK;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            ld_ready_q  <= ld_ready_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        dec         = decode(bus.opcode, bus.xo);

        case (state_q)
            IDLE: begin
                if (bus.ld_valid && ld_ready_q) begin
                    size_d     = dec.size;
                    sgn_d      = dec.sgn;
                    off_d      = bus.address[2:0];
                    mem_addr_d = bus.address[63:3];
                    if (!dec.legal) begin
                        state_d     = RESP;
                        res_valid_d = 1'b1;
                        res_data_d  = 64'd0;
                        res_err_d   = ERR_ILLEGAL;
                    end else if (!is_aligned(dec.size, bus.address[2:0])) begin
                        state_d     = RESP;
                        res_valid_d = 1'b1;
                        res_data_d  = 64'd0;
                        res_err_d   = ERR_MISALIGN;
                    end else begin
                        state_d   = REQ;
                        mem_req_d = 1'b1;
                        cnt_d     = 8'd0;
                    end
                end
            end
            REQ: begin
                // An ack on the final allowed cycle still beats the timeout.
                if (bus.mem_ack) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    res_valid_d = 1'b1;
                    res_data_d  = extract(bus.mem_rdata, off_q, size_q, sgn_q);
                    res_err_d   = ERR_OK;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    res_valid_d = 1'b1;
                    res_data_d  = 64'd0;
                    res_err_d   = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (bus.res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        ld_ready_d = (state_d == IDLE);
    end

    assign bus.ld_ready     = ld_ready_q;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_data     = res_data_q;
    assign bus.res_err_code = res_err_q;

endmodule
